// File: rtl/iic_pkg.sv
// Shared types and constants for the I2C EEPROM command arbiter and its engine.
// State codes are fixed because other blocks may decode them directly.
package iic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } iic_state_e;

    localparam logic       IIC_RD       = 1'b1;
    localparam logic       IIC_WR       = 1'b0;
    localparam logic [6:0] IIC_DEV_ADDR = 7'b1010_000;
    localparam int         IIC_CNT_W    = 24;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: when both requesters are valid, the one not
// granted last time wins. Purely combinational.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       sel,
    output logic       any
);

    always_comb begin
        any = |valid;
        if (&valid) sel = ~last_grant;
        else        sel = valid[1];
    end

endmodule

// File: rtl/iic_arbiter.sv
// Shares one single-byte I2C EEPROM engine between two requesters: round-robin
// grant, engine launch, timeout watchdog and response return.
//
// state | meaning
// IDLE  | waiting for a command; ready offered to the selected requester
// ISSUE | command latched; waiting for engine idle to launch
// WAIT  | engine running; watchdog counting
// RESP  | one-cycle done pulse to the granted requester
module iic_arbiter
    import iic_pkg::*;
#(
    parameter logic [IIC_CNT_W-1:0] TIMEOUT_CYC = 24'd4_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req0_rw,
    input  logic [7:0] req0_wdata,
    output logic       req0_ready,
    output logic       req0_done,
    input  logic       req1_valid,
    input  logic       req1_rw,
    input  logic [7:0] req1_wdata,
    output logic       req1_ready,
    output logic       req1_done,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       eng_start,
    output logic       eng_rw,
    output logic [7:0] eng_wdata,
    input  logic       eng_busy,
    input  logic       eng_done,
    input  logic [7:0] eng_rdata
);

    localparam logic [IIC_CNT_W-1:0] CNT_LIMIT = TIMEOUT_CYC - 24'd1;

    iic_state_e           state_q;
    logic                 last_grant_q;
    logic                 id_q;
    logic                 eng_rw_q;
    logic [7:0]           eng_wdata_q;
    logic [7:0]           rsp_rdata_q;
    logic                 rsp_err_q;
    logic [IIC_CNT_W-1:0] cnt_q;
    logic                 done0_q;
    logic                 done1_q;

    logic sel;
    logic any;
    logic accept;

    rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .sel        (sel),
        .any        (any)
    );

    assign req0_ready = (state_q == ST_IDLE) && any && req0_valid && !sel;
    assign req1_ready = (state_q == ST_IDLE) && any && req1_valid &&  sel;
    assign accept     = req0_ready || req1_ready;

    // Launch is combinational so it lands in the first ISSUE cycle the engine is free.
    assign eng_start = (state_q == ST_ISSUE) && !eng_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            eng_rw_q     <= 1'b0;
            eng_wdata_q  <= 8'h00;
            rsp_rdata_q  <= 8'h00;
            rsp_err_q    <= 1'b0;
            cnt_q        <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        id_q         <= sel;
                        last_grant_q <= sel;
                        eng_rw_q     <= sel ? req1_rw : req0_rw;
                        eng_wdata_q  <= sel ? req1_wdata : req0_wdata;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!eng_busy) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A completion coinciding with the watchdog limit is a success.
                    if (eng_done) begin
                        if (eng_rw_q == IIC_RD) rsp_rdata_q <= eng_rdata;
                        rsp_err_q <= 1'b0;
                        done0_q   <= ~id_q;
                        done1_q   <= id_q;
                        state_q   <= ST_RESP;
                    end else if (cnt_q == CNT_LIMIT) begin
                        rsp_err_q <= 1'b1;
                        done0_q   <= ~id_q;
                        done1_q   <= id_q;
                        state_q   <= ST_RESP;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_done = done0_q;
    assign req1_done = done1_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign eng_rw    = eng_rw_q;
    assign eng_wdata = eng_wdata_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed bench for iic_arbiter: expected responses are queued at accept and
// compared when the done pulse arrives.
module tb_iic_arbiter;
    import iic_pkg::*;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req0_rw = 1'b0;
    logic [7:0] req0_wdata = 8'h00;
    logic       req0_ready, req0_done;
    logic       req1_valid = 1'b0, req1_rw = 1'b0;
    logic [7:0] req1_wdata = 8'h00;
    logic       req1_ready, req1_done;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       eng_start, eng_rw;
    logic [7:0] eng_wdata;
    logic       eng_busy = 1'b0, eng_done = 1'b0;
    logic [7:0] eng_rdata = 8'h00;

    typedef struct {
        logic       id;
        logic       err;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_rdata = 8'h00;
    int         vectors = 0;
    int         miscompares = 0;

    iic_arbiter #(.TIMEOUT_CYC(24'd100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_rw    (req0_rw),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req0_done  (req0_done),
        .req1_valid (req1_valid),
        .req1_rw    (req1_rw),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .req1_done  (req1_done),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_rw     (eng_rw),
        .eng_wdata  (eng_wdata),
        .eng_busy   (eng_busy),
        .eng_done   (eng_done),
        .eng_rdata  (eng_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full command: drive at a negedge, accept at the next posedge, model
    // the engine, then check the response against the queued expectation.
    task automatic do_cmd(input logic id, input logic rw, input logic [7:0] wd,
                          input int busy, input int lat, input logic [7:0] rd,
                          input bit to, input bit both);
        exp_t e;
        int   n;
        if (both) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_rw = rw; req1_rw = rw; req0_wdata = wd; req1_wdata = wd;
        end else begin
            req0_valid = !id; req1_valid = id;
            if (id) begin req1_rw = rw; req1_wdata = wd; end
            else    begin req0_rw = rw; req0_wdata = wd; end
        end
        eng_busy = (busy > 0);
        #1;
        chk("ready0", req0_ready, !id);
        chk("ready1", req1_ready, id);
        e.id  = id;
        e.err = to;
        if (rw == IIC_RD && !to) model_rdata = rd;
        e.rdata = model_rdata;
        e.lat   = to ? TO + 1 : lat + 1;
        sb.push_back(e);
        @(negedge clk);
        if (!both) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        for (int k = 0; k < busy; k++) begin
            #1;
            chk("start_while_busy", eng_start, 1'b0);
            @(negedge clk);
        end
        eng_busy = 1'b0;
        #1;
        chk("eng_start", eng_start, 1'b1);
        chk("eng_rw", eng_rw, rw);
        chk("eng_wdata", eng_wdata, wd);
        chk("ready_off", req0_ready | req1_ready, 1'b0);
        n = 0;
        while (n < TO + 20) begin
            @(negedge clk);
            n++;
            eng_done = 1'b0;
            #1;
            if (n == 1) chk("start_single", eng_start, 1'b0);
            if (req0_done || req1_done) break;
            if (!to && n == lat) begin
                eng_done  = 1'b1;
                eng_rdata = (rw == IIC_RD) ? rd : ~model_rdata;
            end
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("done_latency", n, e.lat);
            chk("done_granted", e.id ? req1_done : req0_done, 1'b1);
            chk("done_other", e.id ? req0_done : req1_done, 1'b0);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_rdata", rsp_rdata, e.rdata);
        end
        @(negedge clk);
        eng_done = 1'b0;
        if (!both) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        #1;
        chk("done_pulse_end", req0_done | req1_done, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
        chk("rst_done", {req0_done, req1_done}, 2'b00);
        chk("rst_start", eng_start, 1'b0);
        chk("rst_eng", {eng_rw, eng_wdata}, 9'h000);
        chk("rst_rsp", {rsp_err, rsp_rdata}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_cmd(1'b0, IIC_WR, 8'hA5, 0, 50, 8'h00, 1'b0, 1'b0);
        do_cmd(1'b1, IIC_RD, 8'h00, 0, 10, 8'h3C, 1'b0, 1'b0);

        // Continuous tie: grants alternate starting with requester 0.
        do_cmd(1'b0, IIC_WR, 8'h11, 0, 3, 8'h00, 1'b0, 1'b1);
        do_cmd(1'b1, IIC_WR, 8'h22, 0, 3, 8'h00, 1'b0, 1'b1);
        do_cmd(1'b0, IIC_WR, 8'h33, 0, 3, 8'h00, 1'b0, 1'b1);
        do_cmd(1'b1, IIC_WR, 8'h44, 0, 3, 8'h00, 1'b0, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        do_cmd(1'b1, IIC_WR, 8'h5E, 20, 7, 8'h00, 1'b0, 1'b0);
        do_cmd(1'b0, IIC_RD, 8'h00, 0, 0, 8'hEE, 1'b1, 1'b0);
        do_cmd(1'b1, IIC_RD, 8'h00, 0, 5, 8'h77, 1'b0, 1'b0);
        do_cmd(1'b0, IIC_RD, 8'h00, 0, TO, 8'hC3, 1'b0, 1'b0);

        // Stray engine completion while idle must be ignored.
        eng_done = 1'b1; eng_rdata = 8'h99;
        @(negedge clk);
        eng_done = 1'b0;
        #1;
        chk("stray_done", {req0_done, req1_done}, 2'b00);
        chk("stray_rdata", rsp_rdata, model_rdata);

        // Reset in the middle of WAIT after a requester-0 grant.
        req0_valid = 1'b1; req0_rw = IIC_RD; req0_wdata = 8'h5A;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("pre_rst_start", eng_start, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_eng", {eng_start, eng_rw, eng_wdata}, 10'h000);
        chk("mid_rst_rsp", {rsp_err, rsp_rdata}, 9'h000);
        chk("mid_rst_done", {req0_done, req1_done}, 2'b00);
        repeat (2) @(negedge clk);
        #1;
        chk("mid_rst_done_hold", {req0_done, req1_done}, 2'b00);
        rst_n = 1'b1;
        model_rdata = 8'h00;
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("post_rst_tie", {req1_ready, req0_ready}, 2'b01);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
